// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter:
// FSM/owner encodings and bus widths.
package sram_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int STALL_W    = 2;
  localparam int STALL_INST = 0;
  localparam int STALL_DATA = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

endpackage

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM/bus port between fetch and data
// requesters; data has fixed priority.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic [DATA_W/8-1:0] mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stallreq_inst,
  output logic                stallreq_data
);

  state_e state_q;
  state_e state_d;
  owner_e owner_q;

  logic [DATA_W/8-1:0] wen_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   irdata_q;
  logic [DATA_W-1:0]   drdata_q;
  logic [STALL_W-1:0]  stall_v;

  logic idle;
  logic take_data;
  logic take_inst;
  logic rsp_fire;

  assign idle      = (state_q == ST_IDLE);
  assign take_data = idle & data_req;
  assign take_inst = idle & inst_req & ~data_req;
  assign rsp_fire  = (state_q == ST_DATA) & mem_data_ok;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (take_data | take_inst) state_d = ST_ADDR;
      ST_ADDR: if (mem_addr_ok) state_d = ST_DATA;
      ST_DATA: if (mem_data_ok) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Everything combinational is forced low while rst
  // is held so the port is quiet in the reset cycle.
  always_comb begin
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    mem_req      = 1'b0;
    stall_v      = '0;
    if (!rst) begin
      unique case (state_q)
        ST_IDLE: begin
          data_addr_ok = data_req;
          inst_addr_ok = inst_req & ~data_req;
        end
        ST_ADDR: mem_req = 1'b1;
        ST_DATA: ;
        ST_RESP: begin
          inst_data_ok = (owner_q == OWN_INST);
          data_data_ok = (owner_q == OWN_DATA);
        end
        default: ;
      endcase
      stall_v[STALL_DATA] =
        (data_req & ~data_addr_ok) |
        ((owner_q == OWN_DATA) &
         (state_q inside {ST_ADDR, ST_DATA}));
      stall_v[STALL_INST] =
        (inst_req & ~inst_addr_ok) |
        ((owner_q == OWN_INST) &
         (state_q inside {ST_ADDR, ST_DATA}));
    end
  end

  assign stallreq_inst = stall_v[STALL_INST];
  assign stallreq_data = stall_v[STALL_DATA];

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_INST;
      wen_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take_data) begin
      owner_q <= OWN_DATA;
      wen_q   <= data_wen;
      addr_q  <= data_addr;
      wdata_q <= data_wdata;
    end else if (take_inst) begin
      owner_q <= OWN_INST;
      wen_q   <= '0;
      addr_q  <= inst_addr;
      wdata_q <= '0;
    end
  end

  // Stores complete through the same path but leave
  // the load data register untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      irdata_q <= '0;
      drdata_q <= '0;
    end else if (rsp_fire) begin
      if (owner_q == OWN_INST)
        irdata_q <= mem_rdata;
      else if (wen_q == '0)
        drdata_q <= mem_rdata;
    end
  end

  assign mem_wen    = wen_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign inst_rdata = irdata_q;
  assign data_rdata = drdata_q;

endmodule
